// File: rtl/mult_cs_pipe_if.sv
// Handshake bundle for mult_cs_pipe: operand side (in_*, a, b, sgn) and result side (out_*, y).
// The master modport is the environment; the slave modport is the multiplier.
interface mult_cs_pipe_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               sgn;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, sgn, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, sgn, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/mult_cs_pipe.sv
// Pipelined carry-save array multiplier with a global-stall valid/ready pipeline.
// Define MULT_SIGNED_EN to compile in Baugh-Wooley two's-complement support selected by sgn.
module mult_cs_pipe #(
  parameter int WIDTH          = 32,
  parameter int ROWS_PER_STAGE = 8
) (
  input logic           clk,
  input logic           rst,
  mult_cs_pipe_if.slave bus
);
  localparam int S = (WIDTH + ROWS_PER_STAGE - 1) / ROWS_PER_STAGE;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] lo;
  } cs_t;

  logic             adv;
  logic [WIDTH-1:0] a_q    [0:S-1];
  logic [WIDTH-1:0] b_q    [0:S-1];
  cs_t              cs_q   [0:S-1];
  cs_t              cs_nxt [0:S-1];
  logic             vld_q  [0:S];
  logic [WIDTH-1:0] y_hi;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

`ifdef MULT_SIGNED_EN
  logic sgn_q [0:S];
`else
  logic unused_sgn;
  assign unused_sgn = bus.sgn;
`endif

  // Valid bits are the only pipeline state that must be cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= S; k++) vld_q[k] <= 1'b0;
    end else if (adv) begin
      vld_q[0] <= bus.in_valid;
      for (int k = 1; k <= S; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      a_q[0] <= bus.a;
      b_q[0] <= bus.b;
      for (int k = 1; k < S; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
      for (int k = 0; k < S; k++) cs_q[k] <= cs_nxt[k];
`ifdef MULT_SIGNED_EN
      sgn_q[0] <= bus.sgn;
      for (int k = 1; k <= S; k++) sgn_q[k] <= sgn_q[k-1];
`endif
    end
  end

  // Stage k reduces rows j with j / ROWS_PER_STAGE == k; each row retires one low bit.
  always_comb begin
    cs_t              acc;
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] fsum;
    logic [WIDTH-1:0] fcar;
    acc  = '0;
    pp   = '0;
    fsum = '0;
    fcar = '0;
    for (int k = 0; k < S; k++) begin
      acc = '0;
      if (k > 0) acc = cs_q[k-1];
      for (int j = 0; j < WIDTH; j++) begin
        if (j / ROWS_PER_STAGE == k) begin
          pp = {WIDTH{a_q[k][j]}} & b_q[k];
`ifdef MULT_SIGNED_EN
          if (sgn_q[k]) begin
            if (j == WIDTH - 1) pp[WIDTH-2:0] = ~pp[WIDTH-2:0];
            else                pp[WIDTH-1]   = ~pp[WIDTH-1];
          end
`endif
          fsum   = acc.s ^ acc.c ^ pp;
          fcar   = (acc.s & acc.c) | (acc.s & pp) | (acc.c & pp);
          acc.lo = {fsum[0], acc.lo[WIDTH-1:1]};
          acc.s  = {1'b0, fsum[WIDTH-1:1]};
          acc.c  = fcar;
        end
      end
      cs_nxt[k] = acc;
    end
  end

  // The Baugh-Wooley constant lands as carry-in (2^WIDTH) plus an MSB flip (2^(2*WIDTH-1)).
  always_comb begin
    logic carry;
    logic si;
    logic ci;
    carry = 1'b0;
`ifdef MULT_SIGNED_EN
    carry = sgn_q[S];
`endif
    y_hi = '0;
    si   = 1'b0;
    ci   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      si      = cs_q[S-1].s[i];
      ci      = cs_q[S-1].c[i];
      y_hi[i] = si ^ ci ^ carry;
      carry   = (si & ci) | (carry & (si ^ ci));
    end
`ifdef MULT_SIGNED_EN
    y_hi[WIDTH-1] = y_hi[WIDTH-1] ^ sgn_q[S];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.y         <= '0;
    end else if (adv) begin
      bus.out_valid <= vld_q[S];
      bus.y         <= {y_hi, cs_q[S-1].lo};
    end
  end
endmodule

// File: tb/tb_mult_cs_pipe.sv
// Directed self-checking bench for mult_cs_pipe (WIDTH=32, ROWS_PER_STAGE=8, latency 6).
// Signed expectations apply when MULT_SIGNED_EN is defined; otherwise sgn must be ignored.
module tb_mult_cs_pipe;
  localparam int W   = 32;
  localparam int R   = 8;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0]   va [16];
  logic [W-1:0]   vb [16];
  logic           vs [16];
  logic [2*W-1:0] vy [16];
  int             nv = 0;

  always #5 clk = ~clk;

  mult_cs_pipe_if #(.WIDTH(W)) bus ();

  mult_cs_pipe #(.WIDTH(W), .ROWS_PER_STAGE(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.sgn      = s;
  endtask

  task automatic addVec(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] y);
    va[nv] = a;
    vb[nv] = b;
    vs[nv] = s;
    vy[nv] = y;
    nv++;
  endtask

  initial begin
    int   lat;
    logic seen;
    int   q;
    int   p;
    int   cyc;
    int   first_c;
    int   last_c;
    int   stall_left;
    logic stall_done;
    logic pending;
    int   extra;

    addVec(32'h0000_0000, 32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000);
    addVec(32'h0000_0001, 32'h0000_0001, 1'b0, 64'h0000_0000_0000_0001);
    addVec(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF);
    addVec(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    addVec(32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000);
    addVec(32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780);
    addVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    addVec(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001);
    addVec(32'h0000_0003, 32'h0000_0005, 1'b0, 64'h0000_0000_0000_000F);
    addVec(32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
    addVec(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 64'h7FFF_FFFF_8000_0000);
`ifdef MULT_SIGNED_EN
    addVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    addVec(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    addVec(32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);
    addVec(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    addVec(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
`else
    addVec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
    addVec(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    addVec(32'h8000_0000, 32'h0000_0001, 1'b1, 64'h0000_0000_8000_0000);
    addVec(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'h0000_0001_FFFF_FFFE);
    addVec(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'h3FFF_FFFF_8000_0000);
`endif

    // Reset state
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_y", bus.y, 64'd0);
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single transaction latency
    $display("[TB] latency check");
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(posedge clk);
    #1;
    lat  = 1;
    seen = bus.out_valid;
    applyStimulus(1'b0, '0, '0, 1'b0);
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = bus.out_valid;
    end
    checkOutput("latency", 64'(lat), 64'(LAT));
    checkOutput("latency_y", bus.y, 64'hFFFF_FFFE_0000_0001);
    @(posedge clk);
    #1;
    checkOutput("latency_pulse_end", 64'(bus.out_valid), 64'd0);

    // Back-to-back stream, one result per cycle
    $display("[TB] streaming check");
    q       = 0;
    first_c = -1;
    last_c  = -1;
    for (int c = 0; c < nv + 20 && q < nv; c++) begin
      @(negedge clk);
      if (c < nv) applyStimulus(1'b1, va[c], vb[c], vs[c]);
      else        applyStimulus(1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        checkOutput($sformatf("stream_%0d", q), bus.y, vy[q]);
        if (first_c < 0) first_c = c;
        last_c = c;
        q++;
      end
    end
    checkOutput("stream_count", 64'(q), 64'(nv));
    checkOutput("stream_first_cycle", 64'(first_c), 64'(LAT - 1));
    checkOutput("stream_contiguous", 64'(last_c - first_c), 64'(nv - 1));

    // Gapped input with a 10-cycle consumer stall
    $display("[TB] stall check");
    applyStimulus(1'b0, '0, '0, 1'b0);
    repeat (LAT + 2) @(negedge clk);
    p          = 0;
    q          = 0;
    cyc        = 0;
    stall_left = 0;
    stall_done = 1'b0;
    pending    = 1'b0;
    while (q < nv && cyc < 300) begin
      @(negedge clk);
      if (!stall_done && cyc >= 8 && bus.out_valid) begin
        stall_left = 10;
        stall_done = 1'b1;
      end
      bus.out_ready = (stall_left == 0);
      if (!pending) begin
        if (p < nv && (cyc % 3) != 2) applyStimulus(1'b1, va[p], vb[p], vs[p]);
        else                          applyStimulus(1'b0, '0, '0, 1'b0);
      end
      #1;
      if (stall_left > 0) begin
        checkOutput($sformatf("stall_in_ready_%0d", stall_left), 64'(bus.in_ready), 64'd0);
        checkOutput($sformatf("stall_out_valid_%0d", stall_left), 64'(bus.out_valid), 64'd1);
        checkOutput($sformatf("stall_y_%0d", stall_left), bus.y, vy[q]);
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        checkOutput($sformatf("stall_stream_%0d", q), bus.y, vy[q]);
        q++;
      end
      pending = bus.in_valid && !bus.in_ready;
      if (bus.in_valid && bus.in_ready) p++;
      cyc++;
    end
    checkOutput("stall_seen", 64'(stall_done), 64'd1);
    checkOutput("stall_count", 64'(q), 64'(nv));
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    checkOutput("stall_no_duplicate", 64'(extra), 64'd0);

    // Reset with four results in flight
    $display("[TB] mid-flight reset check");
    bus.out_ready = 1'b0;
    for (int k = 6; k < 10; k++) begin
      @(negedge clk);
      applyStimulus(1'b1, va[k], vb[k], vs[k]);
    end
    @(negedge clk);
    applyStimulus(1'b0, '0, '0, 1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("flight_head_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("flight_head_y", bus.y, vy[6]);
    checkOutput("flight_in_ready", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midrst_y", bus.y, 64'd0);
    checkOutput("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) extra++;
    end
    checkOutput("midrst_no_ghost", 64'(extra), 64'd0);

    // Pipeline usable after reset
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000_0003, 32'h0000_0005, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("post_rst_latency", 64'(lat), 64'(LAT));
    checkOutput("post_rst_y", bus.y, 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
